// File: rtl/multiport_register_file.sv
// Parametrised multi-port register file with write bypass, optional zero register,
// and a per-register pending-write scoreboard with a registered population count.
module multiport_register_file #(
  parameter int DATA_W   = 16,
  parameter int REG_N    = 16,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int SEL_W   = $clog2(REG_N)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [WR_PORTS-1:0]          WEN,
  input  logic [WR_PORTS*SEL_W-1:0]    wsel,
  input  logic [WR_PORTS*DATA_W-1:0]   wdat,
  input  logic [RD_PORTS*SEL_W-1:0]    rsel,
  output logic [RD_PORTS*DATA_W-1:0]   rdat,
  output logic [RD_PORTS-1:0]          rbusy,
  input  logic                         rsv_en,
  input  logic [SEL_W-1:0]             rsv_sel,
  input  logic                         flush,
  output logic [SEL_W:0]               pending_cnt
);

  logic [DATA_W-1:0] regs   [REG_N];
  logic [DATA_W-1:0] wr_val [REG_N];
  logic [REG_N-1:0]  wr_hit;
  logic [REG_N-1:0]  pending;
  logic [REG_N-1:0]  pending_nxt;
  logic [SEL_W:0]    cnt_nxt;

  // Later ports overwrite earlier ones, so the highest-index matching port wins.
  always_comb begin
    for (int r = 0; r < REG_N; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = regs[r];
      for (int i = 0; i < WR_PORTS; i++) begin
        if (WEN[i] && wsel[i*SEL_W +: SEL_W] == SEL_W'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wdat[i*DATA_W +: DATA_W];
        end
      end
    end
    if (ZERO_REG != 0) begin
      wr_hit[0] = 1'b0;
      wr_val[0] = '0;
    end
  end

  // Flush beats reserve; reserve beats a same-cycle write (new producer issued).
  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < REG_N; r++) begin
      if (flush)
        pending_nxt[r] = 1'b0;
      else if (rsv_en && rsv_sel == SEL_W'(r))
        pending_nxt[r] = 1'b1;
      else if (wr_hit[r])
        pending_nxt[r] = 1'b0;
      else
        pending_nxt[r] = pending[r];
      if (ZERO_REG != 0 && r == 0)
        pending_nxt[r] = 1'b0;
      cnt_nxt = cnt_nxt + (SEL_W+1)'(pending_nxt[r]);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < REG_N; r++)
        regs[r] <= '0;
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      for (int r = 0; r < REG_N; r++)
        regs[r] <= wr_val[r];
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  for (genvar j = 0; j < RD_PORTS; j++) begin : g_rd
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] val;
    logic              busy;

    assign sel = rsel[j*SEL_W +: SEL_W];

    always_comb begin
      val  = regs[sel];
      busy = pending[sel];
      if (BYPASS != 0 && wr_hit[sel]) begin
        val  = wr_val[sel];
        busy = 1'b0;
      end
      if (ZERO_REG != 0 && sel == '0) begin
        val  = '0;
        busy = 1'b0;
      end
    end

    assign rdat[j*DATA_W +: DATA_W] = val;
    assign rbusy[j]                 = busy;
  end

endmodule
